cmd_exec: RTL and testbench

//   Consumer end of the cmd/cmd_arg0/cmd_valid command interface. Accepts one-cycle

---
 rtl/cmd_exec.sv | 161 ++++++++++++++++
 tb/tb_cmd_exec.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_exec.sv
// cmd_exec: turns one-cycle command strobes into seed/step handshakes
// for the Life grid engine, with a one-entry pending slot.
//
// Ports:
//   clk, reset    clock; asynchronous active-high reset
//   cmd*          command code, argument and strobe (no back-pressure)
//   seed_*        seed_start pulse, seed_value held, seed_done ack
//   step_*        step_start pulse, step_done ack
//   busy          high whenever not IDLE
//   gen_count     steps completed since the last completed seed
//   cmd_dropped   pulse: pending command overwritten
//   cmd_bad       pulse: unknown command code ignored
module cmd_exec #(
    parameter int         ARG_W       = 32,
    parameter logic [2:0] CMD_SEED    = 3'd1,
    parameter logic [2:0] CMD_ADVANCE = 3'd2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       cmd,
    input  logic [ARG_W-1:0] cmd_arg0,
    input  logic             cmd_valid,
    output logic             seed_start,
    output logic [ARG_W-1:0] seed_value,
    input  logic             seed_done,
    output logic             step_start,
    input  logic             step_done,
    output logic             busy,
    output logic [ARG_W-1:0] gen_count,
    output logic             cmd_dropped,
    output logic             cmd_bad
);

    typedef enum logic [1:0] {
        IDLE,
        SEED_WAIT,
        STEP_WAIT,
        DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic             pend_v_q, pend_v_d;
    logic             pend_seed_q, pend_seed_d;
    logic [ARG_W-1:0] pend_arg_q, pend_arg_d;
    logic [ARG_W-1:0] rem_q, rem_d;
    logic [ARG_W-1:0] sv_q, sv_d;
    logic [ARG_W-1:0] gen_q, gen_d;
    logic             ss_q, ss_d;
    logic             st_q, st_d;
    logic             drop_q, drop_d;
    logic             bad_q, bad_d;

    logic             is_seed, is_adv, new_ok;
    logic             cand_v, cand_seed;
    logic [ARG_W-1:0] cand_arg;
    logic             stepping, seed_fin, step_fin, free;

    always_comb begin
        is_seed = (cmd == CMD_SEED);
        is_adv  = (cmd == CMD_ADVANCE);
        new_ok  = cmd_valid && (is_seed || is_adv);

        // A new command arriving this cycle supersedes the slot.
        cand_v    = new_ok || pend_v_q;
        cand_seed = new_ok ? is_seed : pend_seed_q;
        cand_arg  = new_ok ? cmd_arg0 : pend_arg_q;

        stepping = (state_q == STEP_WAIT) || (state_q == DRAIN);
        seed_fin = (state_q == SEED_WAIT) && seed_done;
        step_fin = stepping && step_done;

        // free: the engine is idle now and the next command may launch.
        free = (state_q == IDLE) || seed_fin ||
               (step_fin && ((state_q == DRAIN) ||
                             (rem_q == '0) || cand_v));

        state_d     = state_q;
        pend_v_d    = pend_v_q;
        pend_seed_d = pend_seed_q;
        pend_arg_d  = pend_arg_q;
        rem_d       = rem_q;
        sv_d        = sv_q;
        gen_d       = gen_q;
        ss_d        = 1'b0;
        st_d        = 1'b0;
        drop_d      = new_ok && pend_v_q;
        bad_d       = cmd_valid && !new_ok;

        if (seed_fin) gen_d = '0;
        if (step_fin) gen_d = gen_q + 1'b1;

        if (free) begin
            pend_v_d = 1'b0;
            state_d  = IDLE;
            if (cand_v) begin
                if (cand_seed) begin
                    ss_d    = 1'b1;
                    sv_d    = cand_arg;
                    state_d = SEED_WAIT;
                end else if (cand_arg != '0) begin
                    st_d    = 1'b1;
                    rem_d   = cand_arg - 1'b1;
                    state_d = STEP_WAIT;
                end
            end
        end else begin
            // Only reachable with steps left and nothing queued.
            if (step_fin) begin
                st_d  = 1'b1;
                rem_d = rem_q - 1'b1;
            end
            if (new_ok) begin
                pend_v_d    = 1'b1;
                pend_seed_d = is_seed;
                pend_arg_d  = cmd_arg0;
                // A queued command preempts the remaining steps.
                if (stepping) begin
                    rem_d   = '0;
                    state_d = DRAIN;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pend_v_q    <= 1'b0;
            pend_seed_q <= 1'b0;
            pend_arg_q  <= '0;
            rem_q       <= '0;
            sv_q        <= '0;
            gen_q       <= '0;
            ss_q        <= 1'b0;
            st_q        <= 1'b0;
            drop_q      <= 1'b0;
            bad_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_v_q    <= pend_v_d;
            pend_seed_q <= pend_seed_d;
            pend_arg_q  <= pend_arg_d;
            rem_q       <= rem_d;
            sv_q        <= sv_d;
            gen_q       <= gen_d;
            ss_q        <= ss_d;
            st_q        <= st_d;
            drop_q      <= drop_d;
            bad_q       <= bad_d;
        end
    end

    assign seed_start  = ss_q;
    assign seed_value  = sv_q;
    assign step_start  = st_q;
    assign busy        = (state_q != IDLE);
    assign gen_count   = gen_q;
    assign cmd_dropped = drop_q;
    assign cmd_bad     = bad_q;

endmodule

// File: tb/tb_cmd_exec.sv
// tb_cmd_exec: directed scenarios plus random traffic for cmd_exec,
// checked every cycle against a transaction-level reference model.
module tb_cmd_exec;

    localparam logic [2:0] SEED = 3'd1;
    localparam logic [2:0] ADV  = 3'd2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  cmd = '0;
    logic [31:0] cmd_arg0 = '0;
    logic        cmd_valid = 1'b0;
    logic        seed_start, step_start, busy;
    logic [31:0] seed_value, gen_count;
    logic        seed_done = 1'b0, step_done = 1'b0;
    logic        cmd_dropped, cmd_bad;

    cmd_exec dut (
        .clk(clk), .reset(reset),
        .cmd(cmd), .cmd_arg0(cmd_arg0), .cmd_valid(cmd_valid),
        .seed_start(seed_start), .seed_value(seed_value),
        .seed_done(seed_done),
        .step_start(step_start), .step_done(step_done),
        .busy(busy), .gen_count(gen_count),
        .cmd_dropped(cmd_dropped), .cmd_bad(cmd_bad)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: what the engine is doing (0 none, 1 seed,
    // 2 step), steps still owed, the queued command, and outputs.
    int          m_fly;
    logic [31:0] m_rem, m_gen, m_sv, m_parg;
    bit          m_pend, m_pseed;
    bit          e_ss, e_st, e_drop, e_bad;

    // Engine emulation and observed pulse counters.
    int eng_wait, eng_kind, lat_min, lat_max;
    int n_steps, n_seeds, n_drops, n_bads;

    task automatic model_reset();
        m_fly = 0; m_rem = 0; m_gen = 0; m_sv = 0; m_parg = 0;
        m_pend = 0; m_pseed = 0;
        e_ss = 0; e_st = 0; e_drop = 0; e_bad = 0;
        eng_wait = 0; eng_kind = 0;
    endtask

    task automatic model_step(bit v, logic [2:0] c, logic [31:0] a,
                              bit sd, bit td);
        bit known, done_now;
        e_ss = 0; e_st = 0; e_drop = 0; e_bad = 0;
        known = v && (c == SEED || c == ADV);
        e_bad = v && !known;
        done_now = (m_fly == 1 && sd) || (m_fly == 2 && td);
        if (m_fly == 1 && sd) m_gen = 0;
        if (m_fly == 2 && td) m_gen = m_gen + 1;
        if (known) begin
            if (m_pend) e_drop = 1;
            m_pend = 1; m_pseed = (c == SEED); m_parg = a;
            if (m_fly == 2) m_rem = 0;
        end
        if (done_now) begin
            if (m_fly == 2 && m_rem != 0) begin
                e_st = 1; m_rem = m_rem - 1;
            end else m_fly = 0;
        end
        if (m_fly == 0 && m_pend) begin
            m_pend = 0;
            if (m_pseed) begin
                e_ss = 1; m_sv = m_parg; m_fly = 1;
            end else if (m_parg != 0) begin
                e_st = 1; m_rem = m_parg - 1; m_fly = 2;
            end
        end
    endtask

    task automatic check_outs();
        chk("seed_start", seed_start, e_ss);
        chk("step_start", step_start, e_st);
        chk("seed_value", seed_value, m_sv);
        chk("busy", busy, m_fly != 0);
        chk("gen_count", gen_count, m_gen);
        chk("cmd_dropped", cmd_dropped, e_drop);
        chk("cmd_bad", cmd_bad, e_bad);
    endtask

    task automatic cyc(bit v, logic [2:0] c, logic [31:0] a, bit stray);
        bit sd, td;
        sd = 0; td = 0;
        @(negedge clk);
        if (eng_wait > 0) begin
            eng_wait--;
            if (eng_wait == 0) begin
                if (eng_kind == 1) sd = 1;
                else td = 1;
            end
        end
        if (stray) begin
            if (m_fly != 1) sd = 1;
            if (m_fly != 2) td = 1;
        end
        cmd_valid = v; cmd = c; cmd_arg0 = a;
        seed_done = sd; step_done = td;
        model_step(v, c, a, sd, td);
        if (e_ss || e_st) begin
            eng_kind = e_ss ? 1 : 2;
            eng_wait = $urandom_range(lat_max, lat_min);
        end
        @(posedge clk);
        #1;
        check_outs();
        if (step_start) n_steps++;
        if (seed_start) n_seeds++;
        if (cmd_dropped) n_drops++;
        if (cmd_bad) n_bads++;
    endtask

    task automatic wait_idle(int bound);
        int k;
        k = 0;
        while (k < bound && (busy || m_fly != 0)) begin
            cyc(0, 3'd0, 32'd0, 0);
            k++;
        end
        if (k >= bound) chk("idle_timeout", 1, 0);
    endtask

    int b;
    bit rv, rs;
    logic [2:0] rc;
    logic [31:0] ra;

    initial begin
        model_reset();
        n_steps = 0; n_seeds = 0; n_drops = 0; n_bads = 0;
        lat_min = 2; lat_max = 2;
        repeat (3) @(negedge clk);
        check_outs();
        reset = 1'b0;

        // 1: three steps, engine acks two cycles after each start
        b = n_steps;
        cyc(1, ADV, 32'd3, 0);
        wait_idle(40);
        chk("t1_steps", n_steps - b, 3);
        chk("t1_gen", gen_count, 3);

        // 2: seed resets the generation count
        cyc(1, SEED, 32'hDEADBEEF, 0);
        wait_idle(40);
        chk("t2_value", seed_value, 32'hDEADBEEF);
        chk("t2_gen", gen_count, 0);

        // 3: long advance preempted by a seed during the 4th step
        b = n_steps;
        cyc(1, ADV, 32'd1_000_000, 0);
        for (int i = 0; i < 40 && n_steps - b < 4; i++)
            cyc(0, 3'd0, 32'd0, 0);
        chk("t3_gen_before", gen_count, 3);
        cyc(1, SEED, 32'd5, 0);
        wait_idle(40);
        chk("t3_steps", n_steps - b, 4);
        chk("t3_value", seed_value, 5);
        chk("t3_gen", gen_count, 0);

        // 4: two advances queued behind a seed; the first is dropped
        lat_min = 4; lat_max = 4;
        b = n_steps;
        cyc(1, SEED, 32'd1, 0);
        cyc(1, ADV, 32'd2, 0);
        cyc(1, ADV, 32'd7, 0);
        wait_idle(80);
        chk("t4_drops", n_drops, 1);
        chk("t4_steps", n_steps - b, 7);
        chk("t4_gen", gen_count, 7);

        // 5: unknown code and a zero-length advance
        lat_min = 2; lat_max = 2;
        b = n_steps;
        cyc(1, 3'd5, 32'd9, 0);
        cyc(1, ADV, 32'd0, 0);
        cyc(0, 3'd0, 32'd0, 0);
        chk("t5_bads", n_bads, 1);
        chk("t5_steps", n_steps - b, 0);
        chk("t5_busy", busy, 0);

        // 6: asynchronous reset mid-advance, then a stray ack
        cyc(1, ADV, 32'd5, 0);
        cyc(0, 3'd0, 32'd0, 0);
        cyc(0, 3'd0, 32'd0, 0);
        @(negedge clk);
        cmd_valid = 0; seed_done = 0; step_done = 0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("t6_busy", busy, 0);
        chk("t6_gen", gen_count, 0);
        chk("t6_step_start", step_start, 0);
        @(negedge clk);
        reset = 1'b0;
        b = n_steps;
        cyc(0, 3'd0, 32'd0, 1);
        cyc(0, 3'd0, 32'd0, 0);
        chk("t6_no_start", n_steps - b, 0);

        // Random traffic with variable engine latency and stray acks
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            rv = ($urandom_range(5, 0) == 0);
            rs = ($urandom_range(29, 0) == 0);
            case ($urandom_range(9, 0))
                0: rc = ($urandom_range(1, 0) == 0) ? 3'd0
                                                    : 3'($urandom_range(7, 3));
                1, 2, 3, 4: rc = SEED;
                default: rc = ADV;
            endcase
            if (rc == ADV)
                ra = ($urandom_range(7, 0) == 0) ? 32'd1_000_000
                                                 : 32'($urandom_range(4, 0));
            else
                ra = $urandom;
            cyc(rv, rc, ra, rs);
        end
        cyc(1, SEED, 32'h1234_5678, 0);
        wait_idle(100);
        chk("final_gen", gen_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_mis);
        $finish;
    end

endmodule
